// File: rtl/ofdm_delay_corr_if.sv
// Sample-in / correlation-out bundle for ofdm_delay_corr.
// opow exists only when DELAY_CORR_POWER_EN is defined.
interface ofdm_delay_corr_if #(
  parameter int pIDAT_W = 12,
  parameter int pODAT_W = 24
);
  logic                      ival;
  logic signed [pIDAT_W-1:0] idat_re;
  logic signed [pIDAT_W-1:0] idat_im;
  logic                      oval;
  logic signed [pODAT_W-1:0] odat_re;
  logic signed [pODAT_W-1:0] odat_im;
`ifdef DELAY_CORR_POWER_EN
  logic        [pODAT_W-1:0] opow;

  modport master (output ival, idat_re, idat_im, input oval, odat_re, odat_im, opow);
  modport slave  (input ival, idat_re, idat_im, output oval, odat_re, odat_im, opow);
`else
  modport master (output ival, idat_re, idat_im, input oval, odat_re, odat_im);
  modport slave  (input ival, idat_re, idat_im, output oval, odat_re, odat_im);
`endif
endinterface

// File: rtl/ofdm_delay_corr.sv
// Sliding delay-and-correlate R[n] = sum x[n-k]*conj(x[n-k-pDELAY]) over pWIN lags.
// Optional feature macro DELAY_CORR_POWER_EN adds opow = moving sum of |x[n-D]|^2.
module ofdm_delay_corr #(
  parameter int pIDAT_W = 12,
  parameter int pDELAY  = 16,
  parameter int pWIN    = 16,
  parameter int pODAT_W = 24,
  parameter int pSHIFT  = 5
) (
  input logic             iclk,
  input logic             ireset,
  input logic             iclkena,
  ofdm_delay_corr_if.slave bus
);

  localparam int PW    = 2*pIDAT_W + 1;
  localparam int AW    = PW + $clog2(pWIN);
  localparam int PRIME = pDELAY + pWIN - 1;
  localparam int CW    = $clog2(PRIME + 1);
  localparam int DW    = (pDELAY > 1) ? $clog2(pDELAY) : 1;
  localparam int WW    = $clog2(pWIN);

  localparam logic signed [AW-1:0] OMAX = AW'((longint'(1) <<< (pODAT_W-1)) - 1);
  localparam logic signed [AW-1:0] OMIN = -OMAX - AW'(1);

  function automatic logic [pODAT_W-1:0] sat_s(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> pSHIFT;
    if (s > OMAX)      return {1'b0, {(pODAT_W-1){1'b1}}};
    else if (s < OMIN) return {1'b1, {(pODAT_W-1){1'b0}}};
    else               return s[pODAT_W-1:0];
  endfunction

  // S1: delay line and sample registers
  logic signed [pIDAT_W-1:0] dly_re [pDELAY];
  logic signed [pIDAT_W-1:0] dly_im [pDELAY];
  logic [DW-1:0]             dptr;
  logic [CW-1:0]             cnt;
  logic signed [pIDAT_W-1:0] a_re, a_im, b_re, b_im;
  logic                      v1, z1, pr1;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int i = 0; i < pDELAY; i++) begin
        dly_re[i] <= '0;
        dly_im[i] <= '0;
      end
      dptr <= '0;
      cnt  <= '0;
      a_re <= '0;
      a_im <= '0;
      b_re <= '0;
      b_im <= '0;
      v1   <= 1'b0;
      z1   <= 1'b0;
      pr1  <= 1'b0;
    end else if (iclkena) begin
      v1 <= bus.ival;
      if (bus.ival) begin
        a_re         <= bus.idat_re;
        a_im         <= bus.idat_im;
        b_re         <= dly_re[dptr];
        b_im         <= dly_im[dptr];
        dly_re[dptr] <= bus.idat_re;
        dly_im[dptr] <= bus.idat_im;
        dptr         <= (dptr == DW'(pDELAY-1)) ? '0 : dptr + DW'(1);
        z1           <= (cnt < CW'(pDELAY));
        pr1          <= (cnt == CW'(PRIME));
        if (cnt != CW'(PRIME)) cnt <= cnt + CW'(1);
      end
    end
  end

  // S2: conjugate product, full precision
  logic signed [PW-1:0] p_re, p_im;
  logic                 v2, pr2;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      p_re <= '0;
      p_im <= '0;
      v2   <= 1'b0;
      pr2  <= 1'b0;
    end else if (iclkena) begin
      v2  <= v1;
      pr2 <= pr1;
      if (v1) begin
        if (z1) begin
          p_re <= '0;
          p_im <= '0;
        end else begin
          p_re <= PW'(a_re) * PW'(b_re) + PW'(a_im) * PW'(b_im);
          p_im <= PW'(a_im) * PW'(b_re) - PW'(a_re) * PW'(b_im);
        end
      end
    end
  end

  // S3: moving sum via product history; output is the updated sum
  logic signed [PW-1:0] pb_re [pWIN];
  logic signed [PW-1:0] pb_im [pWIN];
  logic [WW-1:0]        wptr;
  logic signed [AW-1:0] acc_re, acc_im, nacc_re, nacc_im;

  always_comb begin
    nacc_re = acc_re + AW'(p_re) - AW'(pb_re[wptr]);
    nacc_im = acc_im + AW'(p_im) - AW'(pb_im[wptr]);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int i = 0; i < pWIN; i++) begin
        pb_re[i] <= '0;
        pb_im[i] <= '0;
      end
      wptr        <= '0;
      acc_re      <= '0;
      acc_im      <= '0;
      bus.oval    <= 1'b0;
      bus.odat_re <= '0;
      bus.odat_im <= '0;
    end else if (iclkena) begin
      bus.oval <= v2 & pr2;
      if (v2) begin
        pb_re[wptr] <= p_re;
        pb_im[wptr] <= p_im;
        wptr        <= wptr + WW'(1);
        acc_re      <= nacc_re;
        acc_im      <= nacc_im;
        bus.odat_re <= sat_s(nacc_re);
        bus.odat_im <= sat_s(nacc_im);
      end
    end
  end

`ifdef DELAY_CORR_POWER_EN
  localparam logic [AW-1:0] UMAX = AW'((longint'(1) << pODAT_W) - 1);

  function automatic logic [pODAT_W-1:0] sat_u(input logic [AW-1:0] v);
    logic [AW-1:0] s;
    s = v >> pSHIFT;
    if (s > UMAX) return {pODAT_W{1'b1}};
    else          return s[pODAT_W-1:0];
  endfunction

  logic [PW-1:0] pw;
  logic [PW-1:0] pb_pw [pWIN];
  logic [AW-1:0] acc_pw, nacc_pw;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      pw <= '0;
    end else if (iclkena && v1) begin
      pw <= z1 ? '0 : PW'(PW'(b_re) * PW'(b_re) + PW'(b_im) * PW'(b_im));
    end
  end

  // Result is never negative, so unsigned wrap of the add/subtract is exact.
  always_comb nacc_pw = acc_pw + AW'(pw) - AW'(pb_pw[wptr]);

  always_ff @(posedge iclk) begin
    if (ireset) begin
      for (int i = 0; i < pWIN; i++) pb_pw[i] <= '0;
      acc_pw   <= '0;
      bus.opow <= '0;
    end else if (iclkena && v2) begin
      pb_pw[wptr] <= pw;
      acc_pw      <= nacc_pw;
      bus.opow    <= sat_u(nacc_pw);
    end
  end
`endif

endmodule
